// File: rtl/zorro_pkg.sv
// zorro_pkg: definitions shared by the Zorro III slave decoders.
//   z3_state_e   : slave handshake states (IDLE / WAIT / HOLD)
//   Z3_SLOT_*    : ADDR[23:17] match values for the 128 KB slots in the 16 MB BAR
//   clog2        : ceiling log2 for parameter arithmetic
//   idx_width    : register-index width, at least one bit
package zorro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } z3_state_e;

  localparam int Z3_MATCH_W = 7;
  localparam int Z3_MAX_WAIT = 7;

  // Slot match values; 7'h46 places the window at BAR offset 0x8C0000.
  localparam logic [6:0] Z3_SLOT_DIP = 7'h46;
  localparam logic [6:0] Z3_SLOT_CFG = 7'h47;
  localparam logic [6:0] Z3_SLOT_AUX = 7'h48;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/zorro_reg_bank.sv
// zorro_reg_bank: NREGS byte registers with per-register reset value and
// per-bit write mask.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   wr_en_i        : commit wdata_i into register idx_i on this edge
//   idx_i          : register index for both read and write
//   wdata_i        : write data
//   rdata_o        : combinational read of register idx_i
//   regs_o         : all register contents, register i at [8i+7:8i]
//   wr_pulse_o     : one-clock pulse, bit i set on the clock after register i is written
module zorro_reg_bank
  import zorro_pkg::*;
#(
  parameter int                 NREGS     = 4,
  parameter logic [NREGS*8-1:0] RESET_VAL = '0,
  parameter logic [NREGS*8-1:0] WR_MASK   = '1
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             wr_en_i,
  input  logic [idx_width(NREGS)-1:0]      idx_i,
  input  logic [7:0]                       wdata_i,
  output logic [7:0]                       rdata_o,
  output logic [NREGS*8-1:0]               regs_o,
  output logic [NREGS-1:0]                 wr_pulse_o
);

  localparam int IDX_W = idx_width(NREGS);

  logic [NREGS*8-1:0] regs_q, regs_d;
  logic [NREGS-1:0]   hit;
  logic [NREGS-1:0]   wr_pulse_q;

  // A single-register bank ignores the index bit, so the byte aliases
  // across the whole window like the original DIP shadow.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NREGS; i++) begin
      hit[i] = (NREGS == 1) || (idx_i == IDX_W'(i));
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (hit[i]) rdata_o = regs_q[8*i +: 8];
    end
  end

  // Masked-off bits keep their current value, which is always the reset value.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_en_i && hit[i]) begin
        regs_d[8*i +: 8] = (wdata_i & WR_MASK[8*i +: 8]) |
                           (regs_q[8*i +: 8] & ~WR_MASK[8*i +: 8]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      regs_q     <= RESET_VAL;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= hit & {NREGS{wr_en_i}};
    end
  end

  assign regs_o     = regs_q;
  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: rtl/zorro_reg_window.sv
// zorro_reg_window: Zorro III slave window exposing NREGS byte registers on
// D31:24 inside a 128 KB slot of the board's 16 MB BAR.
//   CLK, RESET_n          : clock, synchronous active-low reset
//   ADDR[23:2]            : [23:17] slot match, low bits select the register
//   READ, DIN, FCS_n      : Z3 direction, write data, full cycle strobe
//   slave_cycle           : board addressed as slave
//   configured            : autoconfig complete
//   DOUT                  : registered read data, holds between reads
//   sid_dtack             : registered transfer acknowledge
//   SID_n                 : combinational window select, active low
//   regs_q, wr_pulse      : live register contents and per-register write pulse
//
// state | meaning
// IDLE  | no transfer; waits for select with FCS_n low
// WAIT  | cycle latched, counting wait states; FCS_n high aborts
// HOLD  | transfer done, DTACK asserted until FCS_n returns high
module zorro_reg_window
  import zorro_pkg::*;
#(
  parameter logic [6:0]         BASE_MATCH  = Z3_SLOT_DIP,
  parameter int                 NREGS       = 4,
  parameter int                 WAIT_CYCLES = 0,
  parameter logic [NREGS*8-1:0] RESET_VAL   = '0,
  parameter logic [NREGS*8-1:0] WR_MASK     = '1,
  parameter bit                 RO_WINDOW   = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  input  logic [23:2]          ADDR,
  input  logic                 READ,
  input  logic [31:24]         DIN,
  input  logic                 FCS_n,
  input  logic                 slave_cycle,
  input  logic                 configured,
  output logic [31:24]         DOUT,
  output logic                 sid_dtack,
  output logic                 SID_n,
  output logic [NREGS*8-1:0]   regs_q,
  output logic [NREGS-1:0]     wr_pulse
);

  localparam int IDX_W = idx_width(NREGS);

  z3_state_e          state_q;
  logic [2:0]         cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               rd_q;
  logic               dtack_q;
  logic [7:0]         dout_q;

  logic               win_sel;
  logic               bank_wr;
  logic [7:0]         bank_rdata;
  logic               unused_addr;

  // A read-only window never claims write cycles, leaving them to other decoders.
  assign win_sel = slave_cycle && configured &&
                   (ADDR[23:17] == BASE_MATCH) && (READ || !RO_WINDOW);
  assign SID_n   = !win_sel;

  assign unused_addr = ^ADDR[16:2+IDX_W];

  // FCS_n high on the terminal-count edge is an abort, so it gates the write.
  assign bank_wr = (state_q == WAIT) && !FCS_n && (cnt_q == 3'd0) &&
                   !rd_q && !RO_WINDOW;

  zorro_reg_bank #(
    .NREGS     (NREGS),
    .RESET_VAL (RESET_VAL),
    .WR_MASK   (WR_MASK)
  ) u_bank (
    .clk_i      (CLK),
    .rst_n_i    (RESET_n),
    .wr_en_i    (bank_wr),
    .idx_i      (idx_q),
    .wdata_i    (DIN),
    .rdata_o    (bank_rdata),
    .regs_o     (regs_q),
    .wr_pulse_o (wr_pulse)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      dtack_q <= 1'b0;
      dout_q  <= 8'hFF;
    end else begin
      case (state_q)
        IDLE: begin
          dtack_q <= 1'b0;
          if (win_sel && !FCS_n) begin
            idx_q   <= ADDR[2 +: IDX_W];
            rd_q    <= READ;
            cnt_q   <= 3'(WAIT_CYCLES);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (FCS_n) begin
            state_q <= IDLE;
          end else if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            if (rd_q) dout_q <= bank_rdata;
            dtack_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (FCS_n) begin
            dtack_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          dtack_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sid_dtack = dtack_q;
  assign DOUT      = dout_q;

endmodule

// File: tb/tb_zorro_reg_window.sv
// Bench for zorro_reg_window: three instances (default window, masked window
// with three wait states, read-only window with one wait state) share one
// Z3 bus; only the instance whose 'configured' is high responds.
module tb_zorro_reg_window;

  localparam logic [6:0]  BASE = 7'h46;
  localparam logic [31:0] RV_A = 32'h0000_0000, MK_A = 32'hFFFF_FFFF;
  localparam logic [31:0] RV_B = 32'h5A30_00C3, MK_B = 32'hF00F_FF3C;
  localparam logic [31:0] RV_C = 32'hDEAD_BEEF, MK_C = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:2] addr;
  logic        rd;
  logic [7:0]  din;
  logic        fcs_n;
  logic        slave_cycle;
  logic        cfg_a, cfg_b, cfg_c;

  logic [7:0]  dout_a, dout_b, dout_c;
  logic        dtack_a, dtack_b, dtack_c;
  logic        sid_a, sid_b, sid_c;
  logic [31:0] regs_a, regs_b, regs_c;
  logic [3:0]  wrp_a, wrp_b, wrp_c;

  int          cur;
  logic [7:0]  dout_s;
  logic        dtack_s, sid_s;
  logic [31:0] regs_s;
  logic [3:0]  wrp_s;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl      [3][4];
  logic [7:0] mdl_dout [3];

  always #5 clk = ~clk;

  zorro_reg_window #(.BASE_MATCH(BASE), .NREGS(4), .WAIT_CYCLES(0),
                     .RESET_VAL(RV_A), .WR_MASK(MK_A), .RO_WINDOW(1'b0)) u_a (
    .CLK(clk), .RESET_n(rst_n), .ADDR(addr), .READ(rd), .DIN(din), .FCS_n(fcs_n),
    .slave_cycle(slave_cycle), .configured(cfg_a), .DOUT(dout_a),
    .sid_dtack(dtack_a), .SID_n(sid_a), .regs_q(regs_a), .wr_pulse(wrp_a));

  zorro_reg_window #(.BASE_MATCH(BASE), .NREGS(4), .WAIT_CYCLES(3),
                     .RESET_VAL(RV_B), .WR_MASK(MK_B), .RO_WINDOW(1'b0)) u_b (
    .CLK(clk), .RESET_n(rst_n), .ADDR(addr), .READ(rd), .DIN(din), .FCS_n(fcs_n),
    .slave_cycle(slave_cycle), .configured(cfg_b), .DOUT(dout_b),
    .sid_dtack(dtack_b), .SID_n(sid_b), .regs_q(regs_b), .wr_pulse(wrp_b));

  zorro_reg_window #(.BASE_MATCH(BASE), .NREGS(4), .WAIT_CYCLES(1),
                     .RESET_VAL(RV_C), .WR_MASK(MK_C), .RO_WINDOW(1'b1)) u_c (
    .CLK(clk), .RESET_n(rst_n), .ADDR(addr), .READ(rd), .DIN(din), .FCS_n(fcs_n),
    .slave_cycle(slave_cycle), .configured(cfg_c), .DOUT(dout_c),
    .sid_dtack(dtack_c), .SID_n(sid_c), .regs_q(regs_c), .wr_pulse(wrp_c));

  always_comb begin
    dout_s = dout_a; dtack_s = dtack_a; sid_s = sid_a; regs_s = regs_a; wrp_s = wrp_a;
    case (cur)
      1: begin dout_s = dout_b; dtack_s = dtack_b; sid_s = sid_b; regs_s = regs_b; wrp_s = wrp_b; end
      2: begin dout_s = dout_c; dtack_s = dtack_c; sid_s = sid_c; regs_s = regs_c; wrp_s = wrp_c; end
      default: ;
    endcase
  end

  function automatic logic [31:0] rv(input int d);
    return (d == 0) ? RV_A : (d == 1) ? RV_B : RV_C;
  endfunction

  function automatic logic [31:0] mk(input int d);
    return (d == 0) ? MK_A : (d == 1) ? MK_B : MK_C;
  endfunction

  function automatic int wc(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 1;
  endfunction

  function automatic logic [31:0] mdl_vec(input int d);
    return {mdl[d][3], mdl[d][2], mdl[d][1], mdl[d][0]};
  endfunction

  task automatic model_reset();
    logic [31:0] v;
    for (int d = 0; d < 3; d++) begin
      v = rv(d);
      for (int i = 0; i < 4; i++) mdl[d][i] = v[8*i +: 8];
      mdl_dout[d] = 8'hFF;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sel_dut(input int d);
    cur   = d;
    cfg_a = (d == 0);
    cfg_b = (d == 1);
    cfg_c = (d == 2);
  endtask

  task automatic bus_idle();
    fcs_n = 1'b1; slave_cycle = 1'b0; rd = 1'b1;
  endtask

  // Full transfer: select, latency, data/register effect, optional extended hold, release.
  task automatic xfer(input int d, input logic r, input logic [1:0] idx,
                      input logic [7:0] wd, input int hold_extra);
    int          lat;
    logic [7:0]  m, nv;
    logic [31:0] mv;
    bit          early_wp, hold_drop, hold_wp;
    sel_dut(d);
    addr = {BASE, 13'($urandom), idx}; rd = r; din = wd; slave_cycle = 1'b1; fcs_n = 1'b0;
    #1;
    check("sid_selected", 64'(sid_s), 64'(0));
    tick();
    // Latched cycle must ignore later address/direction changes.
    addr = 22'($urandom); rd = 1'($urandom);
    lat = 0; early_wp = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (dtack_s) begin lat = k; break; end
      early_wp |= (wrp_s != 4'b0);
    end
    check("dtack_latency", 64'(lat), 64'(1 + wc(d)));
    check("no_early_wr_pulse", 64'(early_wp), 64'(0));
    if (r) begin
      mdl_dout[d] = mdl[d][idx];
      check("read_data", 64'(dout_s), 64'(mdl_dout[d]));
      check("read_no_wr_pulse", 64'(wrp_s), 64'(0));
    end else begin
      mv = mk(d);
      m  = mv[8*idx +: 8];
      nv = (wd & m) | (mdl[d][idx] & ~m);
      mdl[d][idx] = nv;
      check("wr_pulse_onehot", 64'(wrp_s), 64'(4'b0001 << idx));
      check("dout_holds", 64'(dout_s), 64'(mdl_dout[d]));
    end
    check("regs_after_xfer", 64'(regs_s), 64'(mdl_vec(d)));
    hold_drop = 0; hold_wp = 0;
    for (int k = 0; k < hold_extra; k++) begin
      tick();
      hold_drop |= !dtack_s;
      hold_wp   |= (wrp_s != 4'b0);
    end
    if (hold_extra > 0) begin
      check("dtack_held", 64'(hold_drop), 64'(0));
      check("wr_pulse_single", 64'(hold_wp), 64'(0));
    end
    bus_idle();
    tick();
    check("dtack_release", 64'(dtack_s), 64'(0));
    check("wr_pulse_clear", 64'(wrp_s), 64'(0));
    check("dout_after_release", 64'(dout_s), 64'(mdl_dout[d]));
  endtask

  // Write cycle with FCS_n released after low_edges further edges past the select edge.
  task automatic abort_wr(input int d, input logic [1:0] idx, input logic [7:0] wd,
                          input int low_edges);
    bit seen_dt, seen_wp;
    sel_dut(d);
    addr = {BASE, 13'($urandom), idx}; rd = 1'b0; din = wd; slave_cycle = 1'b1; fcs_n = 1'b0;
    tick();
    for (int k = 0; k < low_edges; k++) tick();
    bus_idle();
    seen_dt = 0; seen_wp = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen_dt |= dtack_s;
      seen_wp |= (wrp_s != 4'b0);
    end
    check("abort_no_dtack", 64'(seen_dt), 64'(0));
    check("abort_no_wr_pulse", 64'(seen_wp), 64'(0));
    check("abort_regs", 64'(regs_s), 64'(mdl_vec(d)));
  endtask

  // Attempted write to the read-only window: not selected, no response.
  task automatic ro_write(input logic [1:0] idx, input logic [7:0] wd);
    bit seen_dt, seen_wp;
    sel_dut(2);
    addr = {BASE, 13'($urandom), idx}; rd = 1'b0; din = wd; slave_cycle = 1'b1; fcs_n = 1'b0;
    #1;
    check("ro_write_sid", 64'(sid_s), 64'(1));
    seen_dt = 0; seen_wp = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen_dt |= dtack_s;
      seen_wp |= (wrp_s != 4'b0);
    end
    bus_idle();
    tick();
    check("ro_write_no_dtack", 64'(seen_dt), 64'(0));
    check("ro_write_no_wr_pulse", 64'(seen_wp), 64'(0));
    check("ro_write_regs", 64'(regs_s), 64'(mdl_vec(2)));
  endtask

  // Read with a wrong slot or while unconfigured: no select, no DTACK.
  task automatic miss(input int d, input logic [6:0] match, input logic cfg);
    bit seen_dt;
    sel_dut(d);
    if (!cfg) begin cfg_a = 1'b0; cfg_b = 1'b0; cfg_c = 1'b0; end
    addr = {match, 13'($urandom), 2'($urandom)}; rd = 1'b1; slave_cycle = 1'b1; fcs_n = 1'b0;
    #1;
    check("miss_sid", 64'(sid_s), 64'(1));
    seen_dt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen_dt |= dtack_s;
    end
    bus_idle();
    tick();
    check("miss_no_dtack", 64'(seen_dt), 64'(0));
    check("miss_dout", 64'(dout_s), 64'(mdl_dout[d]));
  endtask

  initial begin
    int         d;
    logic       r;
    logic [1:0] ix;
    logic [7:0] wd;

    rst_n = 1'b0; addr = '0; din = '0; cur = 0;
    cfg_a = 1'b0; cfg_b = 1'b0; cfg_c = 1'b0;
    bus_idle();
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      cur = i;
      #1;
      check("rst_dtack", 64'(dtack_s), 64'(0));
      check("rst_dout", 64'(dout_s), 64'(8'hFF));
      check("rst_regs", 64'(regs_s), 64'(rv(i)));
      check("rst_wr_pulse", 64'(wrp_s), 64'(0));
      check("rst_sid_unconfigured", 64'(sid_s), 64'(1));
    end

    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 2'(i), 8'h00, 0);
    check("default_read_idx3", 64'(dout_a), 64'(8'h00));

    xfer(1, 1'b0, 2'd2, 8'hA5, 5);
    check("masked_write_byte2", 64'(regs_b[23:16]), 64'(8'h35));
    xfer(1, 1'b1, 2'd2, 8'h00, 0);
    check("masked_readback", 64'(dout_b), 64'(8'h35));

    abort_wr(1, 2'd0, 8'h11, 2);
    abort_wr(1, 2'd3, 8'hEE, 3);
    abort_wr(0, 2'd1, 8'h99, 0);
    xfer(1, 1'b1, 2'd0, 8'h00, 0);
    xfer(0, 1'b1, 2'd1, 8'h00, 0);

    ro_write(2'd1, 8'h42);
    xfer(2, 1'b1, 2'd1, 8'h00, 1);
    check("ro_read_byte1", 64'(dout_c), 64'(8'hBE));

    miss(0, 7'h47, 1'b1);
    miss(0, BASE, 1'b0);

    for (int n = 0; n < 60; n++) begin
      d  = $urandom_range(0, 2);
      r  = 1'($urandom);
      ix = 2'($urandom);
      wd = 8'($urandom);
      if (d == 2 && !r) ro_write(ix, wd);
      else if (!r && $urandom_range(0, 7) == 0) abort_wr(d, ix, wd, $urandom_range(0, wc(d)));
      else xfer(d, r, ix, wd, $urandom_range(0, 2));
    end

    // Reset on the write edge: the write must not commit.
    sel_dut(0);
    addr = {BASE, 13'd0, 2'd3}; rd = 1'b0; din = 8'h77; slave_cycle = 1'b1; fcs_n = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_idle();
    model_reset();
    check("rst_write_edge_regs", 64'(regs_a), 64'(RV_A));
    check("rst_write_edge_wr_pulse", 64'(wrp_a), 64'(0));
    check("rst_write_edge_dtack", 64'(dtack_a), 64'(0));
    tick();

    // Reset while DTACK is held.
    xfer(1, 1'b0, 2'd1, 8'hFF, 0);
    sel_dut(1);
    addr = {BASE, 13'd0, 2'd1}; rd = 1'b1; slave_cycle = 1'b1; fcs_n = 1'b0;
    tick();
    repeat (4) tick();
    check("hold_before_reset", 64'(dtack_b), 64'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_idle();
    model_reset();
    check("rst_hold_dtack", 64'(dtack_b), 64'(0));
    check("rst_hold_regs", 64'(regs_b), 64'(RV_B));
    check("rst_hold_dout", 64'(dout_b), 64'(8'hFF));
    tick();
    xfer(1, 1'b1, 2'd0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zorro_reg_window.md
# zorro_reg_window

Parametrised Zorro III slave register window: decodes a 128 KB slot inside the board's 16 MB Z3 BAR and exposes NREGS byte-wide shadow registers on data lane D31:24. Each register has a reset value and a per-bit write mask. The DTACK handshake has a configurable wait-state count and abort handling. The block generalises the single-byte DIP shadow window and sits beside the other Z3 slave decoders, feeding board configuration bits (termination, mode straps) to the rest of the design.

## Interface
- BASE_MATCH, 7'h46: value compared against ADDR[23:17] (7'h46 = 0x8C0000).
- NREGS, 4: number of byte registers; power of two, 1..16; IDX_W = max(1, clog2(NREGS)).
- WAIT_CYCLES, 0: extra clocks between selection and DTACK, 0..7.
- RESET_VAL, all zero: NREGS*8 bits; register i resets to RESET_VAL[8i+7:8i].
- WR_MASK, all ones: NREGS*8 bits; 1 = bit writable, 0 = bit fixed at its reset value.
- RO_WINDOW, 0: 1 = window decodes reads only and never writes.
- CLK  in  1  system clock; single clock domain.
- RESET_n  in  1  synchronous, active-low reset.
- ADDR  in  [23:2]  Z3 address; [23:17] window match, [2+IDX_W-1:2] register index.
- READ  in  1  1 = read cycle.
- DIN  in  [31:24]  write data.
- FCS_n  in  1  Z3 full cycle strobe, active low.
- slave_cycle  in  1  board addressed as slave.
- configured  in  1  autoconfig complete.
- DOUT  out  [31:24]  registered read data.
- sid_dtack  out  1  registered transfer acknowledge.
- SID_n  out  1  window select, active low, combinational.
- regs_q  out  NREGS*8  live register contents; register i at [8i+7:8i].
- wr_pulse  out  NREGS  one-clock pulse on the clock a register is written.

## Operation
- SID_n = !(slave_cycle && configured && ADDR[23:17]==BASE_MATCH && (READ || !RO_WINDOW)).
- FSM states: IDLE, WAIT, HOLD.
- IDLE: sid_dtack=0. If !SID_n && !FCS_n: latch index and READ, load cnt=WAIT_CYCLES, go to WAIT.
- WAIT, abort: if FCS_n is high, go to IDLE. No transfer, no DTACK.
- WAIT, cnt!=0: decrement cnt.
- WAIT, cnt==0: perform the transfer, set sid_dtack=1, go to HOLD.
  - Read transfer: DOUT <= reg[idx].
  - Write transfer (only when RO_WINDOW=0): reg[idx] <= (DIN & mask) | (reg & ~mask), where mask is that register's WR_MASK byte. Pulse wr_pulse[idx] for one clock.
- HOLD: keep sid_dtack=1 until FCS_n is sampled high, then sid_dtack=0 and go to IDLE. Exactly one transfer per FCS_n assertion.
- Index and READ are latched only in IDLE; address changes after that are ignored.
- DOUT holds its last value between reads.

## Timing
- Reset state: state=IDLE, sid_dtack=0, DOUT=8'hFF, regs_q=RESET_VAL, wr_pulse=0, cnt=0.
- A reset asserted mid-cycle overrides everything on that edge. No write commits on that edge.
- Latency: edge E0 samples the select. DOUT, the register update and sid_dtack=1 all take effect at edge E0+1+WAIT_CYCLES. With WAIT_CYCLES=0 this is the legacy one-clock DTACK.
- sid_dtack falls on the first edge that samples FCS_n high in HOLD.
- IDLE is re-entered on that same edge. A new cycle can be sampled on the following edge at the earliest.
- An abort on the edge where cnt reaches 0 with FCS_n high still aborts: the abort check has priority over the transfer.
- regs_q updates on the write edge. A read in the next cycle returns the new value.

## Structure
- Shared package zorro_pkg: state enum (IDLE/WAIT/HOLD), clog2 function, Z3 window constants (BASE_MATCH values per board slot).
- One sub-module, zorro_reg_bank: NREGS×8 storage with RESET_VAL, WR_MASK, a write strobe plus index, a read mux, and wr_pulse generation.
- The FSM, wait counter and decode stay in zorro_reg_window.

## Test plan
- Reset, then read idx 0..3 with defaults → DOUT=8'h00 each time; sid_dtack rises exactly 1 clock after the sampling edge; DOUT=8'hFF before the first read.
- Write 8'hA5 to idx 2 with WR_MASK byte 2 = 8'h0F and RESET_VAL byte 2 = 8'h30 → regs_q[23:16]=8'h35; wr_pulse=4'b0100 for one clock; readback gives 8'h35.
- WAIT_CYCLES=3 → sid_dtack rises 4 clocks after the sampling edge. Hold FCS_n low 5 more clocks → DTACK stays high. Raise FCS_n → DTACK is low on the next edge.
- WAIT_CYCLES=3, raise FCS_n 2 clocks after selection → no DTACK, no wr_pulse, registers unchanged, FSM returns to IDLE.
- RO_WINDOW=1, write to the window → SID_n stays 1, no DTACK, registers unchanged. A read returns its data normally.
- Mismatched ADDR[23:17]=7'h47, or configured=0 → SID_n=1, no response. Assert RESET_n low in HOLD → sid_dtack=0 and regs_q=RESET_VAL after that edge.
